// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier (master), the product accumulator
// (slave) and the result consumer.
interface product_accumulator_if #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned COUNT  = 4,
  parameter int unsigned ACC_W  = 10,
  parameter int unsigned CNT_W  = $clog2(COUNT + 1)
);
  logic              in_valid;
  logic [PROD_W-1:0] in_product;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  modport master (
    output in_valid, in_product, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_product, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums a frame of up to COUNT unsigned products (early close on flush) and
// presents sum, beat count and sticky overflow on a held output handshake.
module product_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned COUNT  = 4,
  parameter int unsigned ACC_W  = 10,
  parameter int unsigned CNT_W  = $clog2(COUNT + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  product_accumulator_if.slave bus
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               beat;
  logic [SUM_W-1:0]   sum_ext;
  logic               close;

  // in_ready_q is only ever 1 in ACCUM, so it alone qualifies a beat
  assign beat    = bus.in_valid && in_ready_q;
  assign sum_ext = {1'b0, acc_q} + SUM_W'(bus.in_product);

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    close       = 1'b0;

    case (state_q)
      ACCUM: begin
        if (beat) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_q + CNT_W'(1);
        end
        close = (beat && (cnt_d == CNT_W'(COUNT)))
             || (bus.flush && ((cnt_q != '0) || beat));
        if (close) begin
          out_sum_d   = acc_d;
          out_count_d = cnt_d;
          out_ovf_d   = ovf_d;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  // in_ready stays low while reset is held and rises on the first edge after
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives two accumulators (10-bit and 8-bit sums) with the same beats and
// compares every cycle against a frame-level reference model.
module tb_product_accumulator;

  localparam int unsigned PROD_W = 8;
  localparam int unsigned COUNT  = 4;
  localparam int unsigned ACC_A  = 10;
  localparam int unsigned ACC_B  = 8;

  logic              clk;
  logic              reset_n;
  logic              in_valid_t;
  logic [PROD_W-1:0] in_product_t;
  logic              flush_t;
  logic              out_ready_t;

  product_accumulator_if #(.PROD_W(PROD_W), .COUNT(COUNT), .ACC_W(ACC_A)) bus_a ();
  product_accumulator_if #(.PROD_W(PROD_W), .COUNT(COUNT), .ACC_W(ACC_B)) bus_b ();

  assign bus_a.in_valid   = in_valid_t;
  assign bus_a.in_product = in_product_t;
  assign bus_a.flush      = flush_t;
  assign bus_a.out_ready  = out_ready_t;
  assign bus_b.in_valid   = in_valid_t;
  assign bus_b.in_product = in_product_t;
  assign bus_b.flush      = flush_t;
  assign bus_b.out_ready  = out_ready_t;

  product_accumulator #(.PROD_W(PROD_W), .COUNT(COUNT), .ACC_W(ACC_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave)
  );
  product_accumulator #(.PROD_W(PROD_W), .COUNT(COUNT), .ACC_W(ACC_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: list of accepted beats of the open frame plus latched result
  int  frame[$];
  bit  m_hold;
  bit  m_ready;
  int  exp_sum_a, exp_sum_b, exp_cnt;
  bit  exp_ovf_a, exp_ovf_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("a_in_ready",  32'(bus_a.in_ready),     32'(m_ready));
    check("a_out_valid", 32'(bus_a.out_valid),    32'(m_hold));
    check("a_out_sum",   32'(bus_a.out_sum),      32'(exp_sum_a));
    check("a_out_count", 32'(bus_a.out_count),    32'(exp_cnt));
    check("a_overflow",  32'(bus_a.out_overflow), 32'(exp_ovf_a));
    check("b_in_ready",  32'(bus_b.in_ready),     32'(m_ready));
    check("b_out_valid", 32'(bus_b.out_valid),    32'(m_hold));
    check("b_out_sum",   32'(bus_b.out_sum),      32'(exp_sum_b));
    check("b_out_count", 32'(bus_b.out_count),    32'(exp_cnt));
    check("b_overflow",  32'(bus_b.out_overflow), 32'(exp_ovf_b));
  endtask

  // One cycle: check what the previous edge produced, then drive and predict
  task automatic step(input bit v, input int p, input bit f, input bit r);
    int total;
    bit accepted;
    @(negedge clk);
    check_outputs();
    in_valid_t   = v;
    in_product_t = PROD_W'(p);
    flush_t      = f;
    out_ready_t  = r;
    if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else begin
      accepted = v && m_ready;
      if (accepted) frame.push_back(p % 256);
      if ((accepted && frame.size() == COUNT) || (f && frame.size() > 0)) begin
        total = 0;
        foreach (frame[i]) total += frame[i];
        exp_sum_a = total % (1 << ACC_A);
        exp_sum_b = total % (1 << ACC_B);
        exp_ovf_a = (total >= (1 << ACC_A));
        exp_ovf_b = (total >= (1 << ACC_B));
        exp_cnt   = frame.size();
        frame.delete();
        m_hold = 1'b1;
      end
    end
    m_ready = !m_hold;
  endtask

  task automatic model_clear();
    frame.delete();
    m_hold    = 1'b0;
    exp_sum_a = 0;
    exp_sum_b = 0;
    exp_cnt   = 0;
    exp_ovf_a = 1'b0;
    exp_ovf_b = 1'b0;
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge
  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    in_valid_t  = 1'b0;
    flush_t     = 1'b0;
    out_ready_t = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    model_clear();
    m_ready = 1'b0;
    #1 check_outputs();
    #2 reset_n = 1'b1;
    m_ready = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    in_valid_t   = 1'b0;
    in_product_t = '0;
    flush_t      = 1'b0;
    out_ready_t  = 1'b0;
    model_clear();
    m_ready = 1'b0;
    #1 check_outputs();
    #6 reset_n = 1'b1;

    // Full frame with a free-running consumer
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 15, 1'b0, 1'b1);
    step(1'b1, 30, 1'b0, 1'b1);
    step(1'b1, 45, 1'b0, 1'b1);
    step(1'b1, 60, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Overflow frame, then a small frame that must not inherit the flag
    step(1'b1, 200, 1'b0, 1'b1);
    step(1'b1, 100, 1'b0, 1'b1);
    step(1'b1, 0, 1'b0, 1'b1);
    step(1'b1, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Backpressure with a beat waiting upstream
    step(1'b1, 15, 1'b0, 1'b0);
    step(1'b1, 30, 1'b0, 1'b0);
    step(1'b1, 45, 1'b0, 1'b0);
    step(1'b1, 60, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 7, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 1'b1);
    step(1'b1, 7, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Early flush, then a flush on an empty frame
    step(1'b1, 9, 1'b0, 1'b1);
    step(1'b1, 7, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Flush together with a beat, then a flush during HOLD
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 5, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Flush on the beat that completes the frame closes once
    for (int i = 0; i < 3; i++) step(1'b1, 3, 1'b0, 1'b1);
    step(1'b1, 3, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Reset mid-frame discards the partial sum
    step(1'b1, 1, 1'b0, 1'b1);
    step(1'b1, 2, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 1, 1'b0, 1'b1);
    step(1'b1, 2, 1'b0, 1'b1);
    step(1'b1, 3, 1'b0, 1'b1);
    step(1'b1, 4, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Randomised traffic: valid, product, occasional flush, random consumer
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 255)),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 2) != 0));
    end
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
